adc_uart_tx: RTL and testbench

//  Serial transmitter for the AMDS ADC data link. On a trigger it sends four ADC

---
 rtl/adc_uart_tx.sv | 204 ++++++++++++++++++++
 tb/tb_adc_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_uart_tx.sv
// adc_uart_tx: on a trigger, serialises four 16-bit ADC samples as four 3-byte packets
// (0x90|N, MSB, LSB) over one UART line using 8 data bits, even parity and 1 stop bit.
module adc_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned GAP_CLKS     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tx,
  input  logic [15:0] din0,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic [15:0] din3,
  output logic        dout,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] counter_bytes_sent
);

  localparam int unsigned BAUD_W = 8;
  localparam int unsigned GAP_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [GAP_W-1:0]    r_gap;
  logic [2:0]          r_bit;
  logic [1:0]          r_pkt;
  logic [1:0]          r_idx;
  logic [15:0]         r_din0;
  logic [15:0]         r_din1;
  logic [15:0]         r_din2;
  logic [15:0]         r_din3;

  logic [15:0]         w_sample;
  logic [7:0]          w_byte;
  logic                w_bit_end;
  logic                w_gap_end;
  logic                w_last_byte;

  assign w_bit_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_gap_end   = (r_gap == GAP_W'(GAP_CLKS - 1));
  assign w_last_byte = (r_pkt == 2'd3) && (r_idx == 2'd2);

  // Select the byte currently on the wire from the captured samples
  always_comb begin
    w_sample = r_din0;
    w_byte   = 8'h90;
    case (r_pkt)
      2'd0:    w_sample = r_din0;
      2'd1:    w_sample = r_din1;
      2'd2:    w_sample = r_din2;
      default: w_sample = r_din3;
    endcase
    case (r_idx)
      2'd0:    w_byte = 8'h90 | {6'd0, r_pkt};
      2'd1:    w_byte = w_sample[15:8];
      default: w_byte = w_sample[7:0];
    endcase
  end

  // Transmit FSM; line level and status outputs change together with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_baud             <= '0;
      r_gap              <= '0;
      r_bit              <= '0;
      r_pkt              <= '0;
      r_idx              <= '0;
      r_din0             <= '0;
      r_din1             <= '0;
      r_din2             <= '0;
      r_din3             <= '0;
      dout               <= 1'b1;
      busy               <= 1'b0;
      tx_done            <= 1'b0;
      counter_bytes_sent <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          dout    <= 1'b1;
          tx_done <= 1'b0;
          if (start_tx) begin
            r_din0  <= din0;
            r_din1  <= din1;
            r_din2  <= din2;
            r_din3  <= din3;
            r_pkt   <= '0;
            r_idx   <= '0;
            r_state <= S_LOAD;
          end
        end

        // One setup cycle so the line and busy move on the edge after acceptance
        S_LOAD: begin
          dout    <= 1'b0;
          busy    <= 1'b1;
          r_baud  <= '0;
          r_state <= S_START;
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            dout    <= w_byte[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              dout    <= ^w_byte;
              r_state <= S_PARITY;
            end else begin
              r_bit <= r_bit + 3'd1;
              dout  <= w_byte[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            dout    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud             <= '0;
            counter_bytes_sent <= counter_bytes_sent + 16'd1;
            if (w_last_byte) begin
              dout    <= 1'b1;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              r_state <= S_DONE;
            end else begin
              if (r_idx == 2'd2) begin
                r_idx <= '0;
                r_pkt <= r_pkt + 2'd1;
              end else begin
                r_idx <= r_idx + 2'd1;
              end
              if (GAP_CLKS > 0) begin
                r_gap   <= '0;
                dout    <= 1'b1;
                r_state <= S_GAP;
              end else begin
                dout    <= 1'b0;
                r_state <= S_START;
              end
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_GAP: begin
          if (w_gap_end) begin
            r_baud  <= '0;
            dout    <= 1'b0;
            r_state <= S_START;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end

        S_DONE: begin
          tx_done <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          dout    <= 1'b1;
          busy    <= 1'b0;
          tx_done <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_uart_tx.sv
// Bench for adc_uart_tx: compares the line, busy and tx_done cycle by cycle against a
// waveform model built from the frame and byte-order rules, for two parameter sets.
module tb_adc_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned GAP_G = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, g_start;
  logic [15:0] a_d0, a_d1, a_d2, a_d3;
  logic [15:0] g_d0, g_d1, g_d2, g_d3;
  logic        a_dout, a_busy, a_done;
  logic        g_dout, g_busy, g_done;
  logic [15:0] a_cnt, g_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt_a, exp_cnt_g;

  always #5 clk = ~clk;

  adc_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(0)) u_a (
    .clk(clk), .rst(rst), .start_tx(a_start),
    .din0(a_d0), .din1(a_d1), .din2(a_d2), .din3(a_d3),
    .dout(a_dout), .busy(a_busy), .tx_done(a_done), .counter_bytes_sent(a_cnt)
  );

  adc_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP_G)) u_g (
    .clk(clk), .rst(rst), .start_tx(g_start),
    .din0(g_d0), .din1(g_d1), .din2(g_d2), .din3(g_d3),
    .dout(g_dout), .busy(g_busy), .tx_done(g_done), .counter_bytes_sent(g_cnt)
  );

  // Byte b (0..11) of a transmission: header 0x90|N, then MSB, then LSB of sample N
  function automatic logic [7:0] model_byte(input logic [63:0] s, input int b);
    int          pkt;
    logic [15:0] smp;
    pkt = b / 3;
    smp = s[pkt*16 +: 16];
    case (b % 3)
      0:       return 8'h90 | 8'(pkt);
      1:       return smp[15:8];
      default: return smp[7:0];
    endcase
  endfunction

  // Expected line level c cycles after the start_tx sampling edge
  function automatic logic model_line(input logic [63:0] s, input int c, input int gap);
    int          active, per, off, b, w, bitn;
    logic [7:0]  byt;
    active = 132 * CPB + 11 * gap;
    if (c < 1 || c > active) return 1'b1;
    per  = 11 * CPB + gap;
    off  = c - 1;
    b    = off / per;
    w    = off % per;
    if (w >= 11 * int'(CPB)) return 1'b1;
    bitn = w / CPB;
    byt  = model_byte(s, b);
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return byt[bitn-1];
    if (bitn == 9) return ^byt;
    return 1'b1;
  endfunction

  task automatic set_start(input bit g, input logic v);
    if (g) g_start = v;
    else   a_start = v;
  endtask

  // One transmission on DUT a (g=0) or g (g=1); optional disturbance or mid-frame reset
  task automatic run_tx(input bit g, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3,
                        input bit disturb, input int rst_at, input string name);
    int          gap, active, last;
    int          line_err, busy_err, done_err, first_c;
    logic        o_line, o_busy, o_done, e_line;
    logic [63:0] s;
    logic [15:0] o_cnt, e_cnt;
    gap      = g ? int'(GAP_G) : 0;
    active   = 132 * CPB + 11 * gap;
    last     = active + 12;
    s        = {d3, d2, d1, d0};
    line_err = 0; busy_err = 0; done_err = 0; first_c = -1;
    if (g) begin g_d0 = d0; g_d1 = d1; g_d2 = d2; g_d3 = d3; end
    else   begin a_d0 = d0; a_d1 = d1; a_d2 = d2; a_d3 = d3; end
    @(posedge clk); #1;
    set_start(g, 1'b1);
    @(posedge clk); #1;
    set_start(g, 1'b0);
    for (int c = 0; c <= last; c++) begin
      o_line = g ? g_dout : a_dout;
      o_busy = g ? g_busy : a_busy;
      o_done = g ? g_done : a_done;
      e_line = model_line(s, c, gap);
      if (o_line !== e_line) begin
        line_err++;
        if (first_c < 0) first_c = c;
      end
      if (o_busy !== (c >= 1 && c <= active)) busy_err++;
      if (o_done !== (c == active + 1)) done_err++;
      if (rst_at > 0 && c == rst_at) begin
        rst = 1'b1;
        #1;
        total++;
        if ((g ? g_dout : a_dout) !== 1'b1) begin
          bad++; $display("FAIL %s rst_dout: got %b want 1", name, g ? g_dout : a_dout);
        end
        total++;
        if ((g ? g_busy : a_busy) !== 1'b0) begin
          bad++; $display("FAIL %s rst_busy: got %b want 0", name, g ? g_busy : a_busy);
        end
        total++;
        if ((g ? g_cnt : a_cnt) !== 16'h0000) begin
          bad++; $display("FAIL %s rst_cnt: got %h want 0000", name, g ? g_cnt : a_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt_a = '0;
        exp_cnt_g = '0;
        total++;
        if (line_err != 0) begin
          bad++; $display("FAIL %s pre_rst_line: %0d bad cycles, first at %0d", name, line_err, first_c);
        end
        return;
      end
      if (disturb) begin
        if (c == 50) begin
          if (g) g_d0 = ~d0; else a_d0 = ~d0;
        end
        if (c == 99)         set_start(g, 1'b1);
        if (c == 100)        set_start(g, 1'b0);
        if (c == active + 1) set_start(g, 1'b1);
        if (c == active + 2) set_start(g, 1'b0);
      end
      if (c < last) begin
        @(posedge clk); #1;
      end
    end
    if (g) exp_cnt_g = exp_cnt_g + 16'd12;
    else   exp_cnt_a = exp_cnt_a + 16'd12;
    e_cnt = g ? exp_cnt_g : exp_cnt_a;
    o_cnt = g ? g_cnt : a_cnt;
    total++;
    if (line_err != 0) begin
      bad++; $display("FAIL %s line: %0d bad cycles, first at cycle %0d", name, line_err, first_c);
    end
    total++;
    if (busy_err != 0) begin
      bad++; $display("FAIL %s busy: %0d bad cycles, want high for cycles 1..%0d", name, busy_err, active);
    end
    total++;
    if (done_err != 0) begin
      bad++; $display("FAIL %s tx_done: %0d bad cycles, want single pulse at %0d", name, done_err, active + 1);
    end
    total++;
    if (o_cnt !== e_cnt) begin
      bad++; $display("FAIL %s counter: got %h want %h", name, o_cnt, e_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_start = 1'b0; g_start = 1'b0;
    a_d0 = '0; a_d1 = '0; a_d2 = '0; a_d3 = '0;
    g_d0 = '0; g_d1 = '0; g_d2 = '0; g_d3 = '0;
    exp_cnt_a = '0; exp_cnt_g = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_dout !== 1'b1)  begin bad++; $display("FAIL reset_dout_a: got %b want 1", a_dout); end
    total++; if (a_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy_a: got %b want 0", a_busy); end
    total++; if (a_done !== 1'b0)  begin bad++; $display("FAIL reset_done_a: got %b want 0", a_done); end
    total++; if (a_cnt !== 16'h0)  begin bad++; $display("FAIL reset_cnt_a: got %h want 0000", a_cnt); end
    total++; if (g_dout !== 1'b1)  begin bad++; $display("FAIL reset_dout_g: got %b want 1", g_dout); end
    total++; if (g_cnt !== 16'h0)  begin bad++; $display("FAIL reset_cnt_g: got %h want 0000", g_cnt); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    run_tx(1'b0, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 1'b0, 0, "basic");
  endtask

  task automatic test_gap;
    run_tx(1'b1, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 1'b0, 0, "gap");
  endtask

  task automatic test_ignore_start;
    run_tx(1'b0, 16'h5A5A, 16'h0F0F, 16'h8001, 16'h7FFE, 1'b1, 0, "ignore_start");
  endtask

  task automatic test_reset_mid;
    run_tx(1'b0, 16'hDEAD, 16'hBEEF, 16'hC0DE, 16'hF00D, 1'b0, 1 + 7 * 11 * CPB + 10, "reset_mid");
    run_tx(1'b0, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random;
    bit g;
    for (int i = 0; i < 6; i++) begin
      g = 1'($urandom_range(0, 1));
      run_tx(g, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0, "random");
    end
  endtask

  task automatic test_wrap;
    repeat (2) @(posedge clk);
    #2;
    force u_a.counter_bytes_sent = 16'hFFFA;
    #1;
    release u_a.counter_bytes_sent;
    exp_cnt_a = 16'hFFFA;
    run_tx(1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 0, "wrap");
    total++;
    if (a_cnt !== 16'h0006) begin
      bad++; $display("FAIL wrap_value: got %h want 0006", a_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
